led_cmd_sched: RTL and testbench

Command scheduler for the LED pattern FSM. Turns board buttons into single-cycle one-hot commands and, when auto mode is on, plays a fixed four-entry mode program with a fixed dwell per entry. Manual presses override the program. Output `cmd` drives the pattern FSM's 4-bit one-hot command input directly; that FSM holds its state, so a one-cycle pulse is enough.

---
 rtl/led_cmd_sched.sv | 218 +++++++++++++++++++++
 tb/tb_led_cmd_sched.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_cmd_sched.sv
// Command scheduler for the LED pattern FSM: button edges and a fixed four-entry
// auto program become one-cycle one-hot commands. Define LED_SCHED_HOLDOFF_EN for manual holdoff.
module led_cmd_sched #(
   parameter int unsigned TICK_CYCLES = 125000000,
   parameter int unsigned DWELL_TICKS = 4,
   parameter logic [7:0]  PROG_MODES  = 8'hE4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] btn,
   input  logic       auto_en,
   output logic [3:0] cmd,
   output logic [1:0] mode,
   output logic [1:0] step,
   output logic       auto_active
);

   localparam int unsigned CNT_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
   localparam int unsigned DW_W  = 8;
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TICK_CYCLES - 1);
   localparam logic [DW_W-1:0]  DWELL_LD = DW_W'(DWELL_TICKS);

   typedef enum logic [1:0] {
      S_IDLE       = 2'd0,
      S_AUTO_ISSUE = 2'd1,
      S_AUTO_WAIT  = 2'd2,
      S_MANUAL     = 2'd3
   } state_e;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [3:0]       btn_q;
   logic [1:0]       step_q, step_d;
   logic [DW_W-1:0]  dwell_q, dwell_d;
   logic [3:0]       cmd_q, cmd_d;
   logic [1:0]       mode_q, mode_d;
   logic             auto_active_q, auto_active_d;
`ifdef LED_SCHED_HOLDOFF_EN
   logic [DW_W-1:0]  holdoff_q, holdoff_d;
`endif

   logic       tick;
   logic [3:0] rise;
   logic       rise_any;
   logic [1:0] rise_idx;
   logic [1:0] prog_code;
   logic       dwell_done;
   logic       issue;
   logic [1:0] issue_code;

   // Free-running tick counter; never realigned to the program.
   assign tick  = (cnt_q == CNT_MAX);
   assign cnt_d = tick ? '0 : cnt_q + CNT_W'(1);

   // Rising-edge detect with lowest-index priority.
   assign rise     = btn & ~btn_q;
   assign rise_any = |rise;

   always_comb begin
      rise_idx = 2'd0;
      if      (rise[0]) rise_idx = 2'd0;
      else if (rise[1]) rise_idx = 2'd1;
      else if (rise[2]) rise_idx = 2'd2;
      else if (rise[3]) rise_idx = 2'd3;
   end

   assign prog_code  = PROG_MODES[{step_q, 1'b0} +: 2];
   assign dwell_done = tick && (dwell_q <= DW_W'(1));

   // Next-state, counters and registered-output next values.
   always_comb begin
      state_d    = state_q;
      step_d     = step_q;
      dwell_d    = dwell_q;
`ifdef LED_SCHED_HOLDOFF_EN
      holdoff_d  = holdoff_q;
`endif
      issue      = 1'b0;
      issue_code = 2'd0;

      case (state_q)
         S_IDLE: begin
            step_d = 2'd0;
            if (rise_any) begin
               issue      = 1'b1;
               issue_code = rise_idx;
            end
            if (auto_en) begin
`ifdef LED_SCHED_HOLDOFF_EN
               if (rise_any) begin
                  state_d   = S_MANUAL;
                  holdoff_d = DWELL_LD;
               end else begin
                  state_d = S_AUTO_ISSUE;
               end
`else
               state_d = S_AUTO_ISSUE;
`endif
            end
         end

         S_AUTO_ISSUE: begin
            issue      = 1'b1;
            issue_code = prog_code;
            dwell_d    = DWELL_LD;
            state_d    = S_AUTO_WAIT;
         end

         S_AUTO_WAIT: begin
            if (!auto_en) begin
               state_d = S_IDLE;
               step_d  = 2'd0;
               dwell_d = '0;
`ifdef LED_SCHED_HOLDOFF_EN
            end else if (rise_any) begin
               issue      = 1'b1;
               issue_code = rise_idx;
               dwell_d    = '0;
               holdoff_d  = DWELL_LD;
               state_d    = S_MANUAL;
            end else if (tick) begin
               if (dwell_done) begin
                  dwell_d = '0;
                  step_d  = step_q + 2'd1;
                  state_d = S_AUTO_ISSUE;
               end else begin
                  dwell_d = dwell_q - DW_W'(1);
               end
            end
`else
            end else begin
               // Without holdoff a press is a side command; the program keeps its timing.
               if (rise_any) begin
                  issue      = 1'b1;
                  issue_code = rise_idx;
               end
               if (tick) begin
                  if (dwell_done) begin
                     dwell_d = '0;
                     step_d  = step_q + 2'd1;
                     state_d = S_AUTO_ISSUE;
                  end else begin
                     dwell_d = dwell_q - DW_W'(1);
                  end
               end
            end
`endif
         end

`ifdef LED_SCHED_HOLDOFF_EN
         S_MANUAL: begin
            if (!auto_en) begin
               state_d   = S_IDLE;
               step_d    = 2'd0;
               holdoff_d = '0;
            end else if (rise_any) begin
               issue      = 1'b1;
               issue_code = rise_idx;
               holdoff_d  = DWELL_LD;
            end else if (tick) begin
               // Expiry replays the interrupted entry from its start.
               if (holdoff_q <= DW_W'(1)) begin
                  holdoff_d = '0;
                  state_d   = S_AUTO_ISSUE;
               end else begin
                  holdoff_d = holdoff_q - DW_W'(1);
               end
            end
         end
`endif

         default: begin
            state_d = S_IDLE;
            step_d  = 2'd0;
            dwell_d = '0;
         end
      endcase

      cmd_d         = issue ? (4'b0001 << issue_code) : 4'b0000;
      mode_d        = issue ? issue_code : mode_q;
      auto_active_d = (state_d == S_AUTO_ISSUE) || (state_d == S_AUTO_WAIT);
   end

   // State and output registers; btn_q resets high so held buttons are not presses.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= S_IDLE;
         cnt_q         <= '0;
         btn_q         <= 4'hF;
         step_q        <= 2'd0;
         dwell_q       <= '0;
         cmd_q         <= 4'b0000;
         mode_q        <= 2'd0;
         auto_active_q <= 1'b0;
`ifdef LED_SCHED_HOLDOFF_EN
         holdoff_q     <= '0;
`endif
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         btn_q         <= btn;
         step_q        <= step_d;
         dwell_q       <= dwell_d;
         cmd_q         <= cmd_d;
         mode_q        <= mode_d;
         auto_active_q <= auto_active_d;
`ifdef LED_SCHED_HOLDOFF_EN
         holdoff_q     <= holdoff_d;
`endif
      end
   end

   assign cmd         = cmd_q;
   assign mode        = mode_q;
   assign step        = step_q;
   assign auto_active = auto_active_q;

endmodule

// File: tb/tb_led_cmd_sched.sv
// Self-checking bench for led_cmd_sched against a tick-deadline reference model.
module tb_led_cmd_sched;

   localparam int unsigned TICK  = 4;
   localparam int unsigned DWELL = 2;
   localparam logic [7:0]  PROG  = 8'hE4;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] btn;
   logic       auto_en;
   logic [3:0] cmd;
   logic [1:0] mode;
   logic [1:0] step;
   logic       auto_active;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: absolute tick count plus deadlines instead of down-counters.
   int         m_cnt, m_ticks, m_deadline;
   bit         m_pending, m_wait, m_hold;
   logic [3:0] m_prev;
   logic [3:0] e_cmd;
   logic [1:0] e_mode, e_step;
   logic       e_auto;

   always #5 clk = ~clk;

   led_cmd_sched #(
      .TICK_CYCLES(TICK),
      .DWELL_TICKS(DWELL),
      .PROG_MODES (PROG)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .btn        (btn),
      .auto_en    (auto_en),
      .cmd        (cmd),
      .mode       (mode),
      .step       (step),
      .auto_active(auto_active)
   );

   function automatic int lowest(input logic [3:0] v);
      for (int i = 0; i < 4; i++) if (v[i]) return i;
      return -1;
   endfunction

   function automatic int prog_at(input logic [1:0] s);
      logic [7:0] p;
      p = PROG;
      return int'((p >> (2 * s)) & 8'h03);
   endfunction

   task automatic m_issue(input int code);
      e_cmd  = 4'(1 << code);
      e_mode = 2'(code);
   endtask

   task automatic model_edge();
      int         p;
      bit         tk;
      logic [3:0] r;
      if (rst) begin
         m_cnt = 0; m_ticks = 0; m_deadline = 0;
         m_pending = 0; m_wait = 0; m_hold = 0;
         m_prev = 4'hF; e_cmd = 4'h0; e_mode = 2'd0; e_step = 2'd0; e_auto = 1'b0;
         return;
      end
      tk = (m_cnt == TICK - 1);
      if (tk) m_ticks++;
      r = btn & ~m_prev;
      p = lowest(r);
      e_cmd = 4'h0;
      if (m_pending) begin
         m_issue(prog_at(e_step));
         m_pending = 0; m_wait = 1; m_deadline = m_ticks + DWELL;
      end else if (m_wait) begin
         if (!auto_en) begin
            m_wait = 0; e_step = 2'd0;
`ifdef LED_SCHED_HOLDOFF_EN
         end else if (p >= 0) begin
            m_issue(p); m_wait = 0; m_hold = 1; m_deadline = m_ticks + DWELL;
         end else if (tk && m_ticks == m_deadline) begin
            e_step = e_step + 2'd1; m_wait = 0; m_pending = 1;
         end
`else
         end else begin
            if (p >= 0) m_issue(p);
            if (tk && m_ticks == m_deadline) begin
               e_step = e_step + 2'd1; m_wait = 0; m_pending = 1;
            end
         end
`endif
      end else if (m_hold) begin
         if (!auto_en) begin
            m_hold = 0; e_step = 2'd0;
         end else if (p >= 0) begin
            m_issue(p); m_deadline = m_ticks + DWELL;
         end else if (tk && m_ticks == m_deadline) begin
            m_hold = 0; m_pending = 1;
         end
      end else begin
         e_step = 2'd0;
         if (p >= 0) m_issue(p);
         if (auto_en) begin
`ifdef LED_SCHED_HOLDOFF_EN
            if (p >= 0) begin m_hold = 1; m_deadline = m_ticks + DWELL; end
            else m_pending = 1;
`else
            m_pending = 1;
`endif
         end
      end
      m_cnt  = (m_cnt + 1) % TICK;
      m_prev = btn;
      e_auto = m_pending || m_wait;
   endtask

   // One clock: DUT and model advance on the same edge, outputs sampled at negedge.
   task automatic clk_step();
      @(posedge clk);
      model_edge();
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1; btn = 4'b0010; auto_en = 1'b0;
      repeat (3) clk_step();
      n_checks++;
      if ({cmd, mode, step, auto_active} !== 9'b0) begin
         n_fail++;
         $display("FAIL reset_values: got %b, expected %b", {cmd, mode, step, auto_active}, 9'b0);
      end
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         clk_step();
         n_checks++;
         if (cmd !== 4'b0000) begin
            n_fail++;
            $display("FAIL held_btn_no_cmd: got cmd=%b, expected 0000", cmd);
         end
      end
      btn = 4'b0000;
      clk_step();
      btn = 4'b0010;
      clk_step();
      n_checks++;
      if (cmd !== 4'b0010 || mode !== 2'b01) begin
         n_fail++;
         $display("FAIL repress_btn1: got cmd=%b mode=%b, expected cmd=0010 mode=01", cmd, mode);
      end
      clk_step();
      n_checks++;
      if (cmd !== 4'b0000 || mode !== 2'b01) begin
         n_fail++;
         $display("FAIL pulse_width: got cmd=%b mode=%b, expected cmd=0000 mode=01", cmd, mode);
      end
   endtask

   task automatic test_simultaneous();
      btn = 4'b0000;
      clk_step();
      btn = 4'b0110;
      clk_step();
      n_checks++;
      if (cmd !== 4'b0010 || mode !== 2'b01) begin
         n_fail++;
         $display("FAIL simultaneous_lowest: got cmd=%b mode=%b, expected cmd=0010 mode=01", cmd, mode);
      end
      btn = 4'b0000;
      for (int i = 0; i < 3; i++) begin
         clk_step();
         n_checks++;
         if (cmd !== 4'b0000) begin
            n_fail++;
            $display("FAIL simultaneous_dropped: got cmd=%b, expected 0000", cmd);
         end
      end
   endtask

   task automatic test_auto_playback();
      logic [3:0] pc[$];
      logic [1:0] ps[$];
      int         first_i;
      logic [3:0] exp_c[5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      logic [1:0] exp_s[5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
      first_i = -1;
      auto_en = 1'b1;
      for (int i = 0; i < 45; i++) begin
         clk_step();
         n_checks++;
         if ({cmd, mode, step, auto_active} !== {e_cmd, e_mode, e_step, e_auto}) begin
            n_fail++;
            $display("FAIL playback_model i=%0d: got %b, expected %b", i,
                     {cmd, mode, step, auto_active}, {e_cmd, e_mode, e_step, e_auto});
         end
         n_checks++;
         if (auto_active !== 1'b1) begin
            n_fail++;
            $display("FAIL playback_active i=%0d: got %b, expected 1", i, auto_active);
         end
         if (cmd !== 4'b0000) begin
            if (first_i < 0) first_i = i;
            pc.push_back(cmd);
            ps.push_back(step);
         end
      end
      n_checks++;
      if (first_i !== 1) begin
         n_fail++;
         $display("FAIL playback_first_latency: got %0d, expected 1", first_i);
      end
      n_checks++;
      if (pc.size() < 5) begin
         n_fail++;
         $display("FAIL playback_count: got %0d pulses, expected at least 5", pc.size());
      end else begin
         for (int k = 0; k < 5; k++) begin
            n_checks++;
            if (pc[k] !== exp_c[k] || ps[k] !== exp_s[k]) begin
               n_fail++;
               $display("FAIL playback_seq k=%0d: got cmd=%b step=%0d, expected cmd=%b step=%0d",
                        k, pc[k], ps[k], exp_c[k], exp_s[k]);
            end
         end
      end
   endtask

   task automatic test_override();
      bit         found;
      logic [3:0] next_c;
      found = 0;
      for (int i = 0; i < 40 && !found; i++) begin
         clk_step();
         if (cmd === 4'b0010 && auto_active === 1'b1) found = 1;
      end
      n_checks++;
      if (!found) begin
         n_fail++;
         $display("FAIL override_wait_entry1: got timeout, expected cmd=0010 within 40 cycles");
      end
      btn = 4'b1000;
      clk_step();
      n_checks++;
      if (cmd !== 4'b1000 || mode !== 2'b11) begin
         n_fail++;
         $display("FAIL override_press: got cmd=%b mode=%b, expected cmd=1000 mode=11", cmd, mode);
      end
      btn = 4'b0000;
      clk_step();
      btn = 4'b1000;
      clk_step();
      n_checks++;
      if (cmd !== 4'b1000) begin
         n_fail++;
         $display("FAIL override_repress: got cmd=%b, expected 1000", cmd);
      end
      btn = 4'b0000;
      next_c = 4'b0000;
      for (int i = 0; i < 30; i++) begin
         clk_step();
         n_checks++;
         if ({cmd, mode, step, auto_active} !== {e_cmd, e_mode, e_step, e_auto}) begin
            n_fail++;
            $display("FAIL override_model i=%0d: got %b, expected %b", i,
                     {cmd, mode, step, auto_active}, {e_cmd, e_mode, e_step, e_auto});
         end
         if (cmd !== 4'b0000 && next_c === 4'b0000) next_c = cmd;
      end
      n_checks++;
`ifdef LED_SCHED_HOLDOFF_EN
      if (next_c !== 4'b0010) begin
         n_fail++;
         $display("FAIL override_replay: got cmd=%b, expected 0010", next_c);
      end
`else
      if (next_c !== 4'b0100) begin
         n_fail++;
         $display("FAIL override_continue: got cmd=%b, expected 0100", next_c);
      end
`endif
   endtask

   task automatic test_disable_and_reset();
      bit found;
      auto_en = 1'b1;
      found = 0;
      for (int i = 0; i < 40 && !found; i++) begin
         clk_step();
         if (cmd !== 4'b0000 && auto_active === 1'b1) found = 1;
      end
      auto_en = 1'b0;
      clk_step();
      n_checks++;
      if (!found || auto_active !== 1'b0 || step !== 2'd0 || cmd !== 4'b0000) begin
         n_fail++;
         $display("FAIL disable_mid_dwell: found=%0d got act=%b step=%0d cmd=%b, expected act=0 step=0 cmd=0000",
                  found, auto_active, step, cmd);
      end
      auto_en = 1'b1;
      found = 0;
      for (int i = 0; i < 40 && !found; i++) begin
         clk_step();
         if (cmd !== 4'b0000 && auto_active === 1'b1) found = 1;
      end
      clk_step();
      rst = 1'b1;
      clk_step();
      n_checks++;
      if (!found || {cmd, mode, step, auto_active} !== 9'b0) begin
         n_fail++;
         $display("FAIL reset_mid_dwell: found=%0d got %b, expected %b", found,
                  {cmd, mode, step, auto_active}, 9'b0);
      end
      rst = 1'b0;
      auto_en = 1'b0;
      clk_step();
      n_checks++;
      if ({cmd, mode, step, auto_active} !== {e_cmd, e_mode, e_step, e_auto}) begin
         n_fail++;
         $display("FAIL after_reset_model: got %b, expected %b",
                  {cmd, mode, step, auto_active}, {e_cmd, e_mode, e_step, e_auto});
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 1500; i++) begin
         int idx;
         rst = ($urandom_range(0, 199) == 0);
         if ($urandom_range(0, 19) == 0) begin
            btn = 4'($urandom);
         end else if ($urandom_range(0, 4) == 0) begin
            idx = int'($urandom_range(0, 3));
            btn[idx] = ~btn[idx];
         end
         if ($urandom_range(0, 39) == 0) auto_en = ~auto_en;
         clk_step();
         n_checks++;
         if ({cmd, mode, step, auto_active} !== {e_cmd, e_mode, e_step, e_auto}) begin
            n_fail++;
            $display("FAIL random_model i=%0d: got %b, expected %b", i,
                     {cmd, mode, step, auto_active}, {e_cmd, e_mode, e_step, e_auto});
         end
      end
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      btn = 4'b0000;
      auto_en = 1'b0;
      test_reset();
      test_simultaneous();
      test_auto_playback();
      test_override();
      test_disable_and_reset();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
